// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Timing defaults assume the 12 MHz board clock.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } hold_state_t;

  localparam int unsigned DEB_10MS   = 120000;
  localparam int unsigned HOLD_500MS = 6000000;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: polarity normalisation, 2-flop synchroniser,
// debounce counter and hold FSM producing level and single-cycle pulses.
module button_debounce_ch
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
  parameter int unsigned HOLD_CYCLES     = HOLD_500MS,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DEBOUNCE_CYCLES[DW-1:0];
  localparam logic [HW-1:0] HOLD_MAX = HOLD_CYCLES[HW-1:0];

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  hold_state_t   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_cnt_inc;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          rise, fall;

  // Resetting the synchroniser to 0 (normalised) keeps a held button from glitching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw ^ ACTIVE_LOW;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    stable_d    = stable_q;
    deb_cnt_d   = '0;
    deb_cnt_inc = deb_cnt_q + 1'b1;
    if (sync2_q != stable_q) begin
      if (deb_cnt_inc == DEB_MAX) begin
        stable_d = ~stable_q;
      end else begin
        deb_cnt_d = deb_cnt_inc;
      end
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  // A falling level wins over the hold count, so long and release never coincide.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    hold_cnt_inc = hold_cnt_q + 1'b1;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_inc;
          if (hold_cnt_inc == HOLD_MAX) begin
            state_d = ST_HELD;
            long_d  = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: one independent debounce/hold
// channel per button pin.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned       N_BTN           = 3,
  parameter int unsigned       DEBOUNCE_CYCLES = DEB_10MS,
  parameter int unsigned       HOLD_CYCLES     = HOLD_500MS,
  parameter logic [N_BTN-1:0]  ACTIVE_LOW      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW[gi])
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[gi]),
      .btn_level   (btn_level[gi]),
      .btn_press   (btn_press[gi]),
      .btn_release (btn_release[gi]),
      .btn_long    (btn_long[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios then random pin activity,
// checked every cycle against an edge-count reference model.
module tb_button_debounce;

  localparam int N = 3;
  localparam int D = 4;
  localparam int H = 10;
  localparam logic [N-1:0] AL = 3'b100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0;

  logic [N-1:0] norm_hist [0:8191];
  bit           rst_hist  [0:8191];
  int           run_m     [N];
  bit           stable_m  [N];
  int           press_at  [N];
  logic [N-1:0] exp_level, exp_press, exp_release, exp_long;

  int n_press[N], n_release[N], n_long[N];
  int t_press[N], t_release[N], t_long[N];
  int remain[N];

  button_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int ch = 0; ch < N; ch++) begin
      run_m[ch]    = 0;
      stable_m[ch] = 1'b0;
      press_at[ch] = -1000;
    end
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
  endtask

  // Debounce input at edge t is the pin seen at edge t-2, forced inactive
  // if reset covered either of the two preceding edges.
  task automatic model_step();
    bit eff;
    rst_hist[cyc]  = !rst_n;
    norm_hist[cyc] = btn_raw ^ AL;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int ch = 0; ch < N; ch++) begin
      if (cyc < 2 || rst_hist[cyc-1] || rst_hist[cyc-2]) eff = 1'b0;
      else eff = norm_hist[cyc-2][ch];
      if (eff != stable_m[ch]) begin
        run_m[ch]++;
        if (run_m[ch] == D) begin
          stable_m[ch] = ~stable_m[ch];
          run_m[ch] = 0;
          if (stable_m[ch]) begin
            exp_press[ch] = 1'b1;
            press_at[ch]  = cyc;
          end else begin
            exp_release[ch] = 1'b1;
          end
        end
      end else begin
        run_m[ch] = 0;
      end
      if (stable_m[ch] && (cyc - press_at[ch] == H)) exp_long[ch] = 1'b1;
      exp_level[ch] = stable_m[ch];
    end
  endtask

  task automatic check_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_level"}, btn_level, '0);
    check_vec({tag, "_press"}, btn_press, '0);
    check_vec({tag, "_release"}, btn_release, '0);
    check_vec({tag, "_long"}, btn_long, '0);
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < N; ch++) begin
      n_press[ch] = 0; n_release[ch] = 0; n_long[ch] = 0;
      t_press[ch] = -1; t_release[ch] = -1; t_long[ch] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_vec("level", btn_level, exp_level);
    check_vec("press", btn_press, exp_press);
    check_vec("release", btn_release, exp_release);
    check_vec("long", btn_long, exp_long);
    for (int ch = 0; ch < N; ch++) begin
      if (btn_press[ch])   begin n_press[ch]++;   t_press[ch]   = cyc; end
      if (btn_release[ch]) begin n_release[ch]++; t_release[ch] = cyc; end
      if (btn_long[ch])    begin n_long[ch]++;    t_long[ch]    = cyc; end
    end
    $display("cyc=%0d rst_n=%b raw=%b level=%b press=%b release=%b long=%b",
             cyc, rst_n, btn_raw, btn_level, btn_press, btn_release, btn_long);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = AL;
    model_clear();
    clear_obs();
    #1;
    check_zero("reset_init");
    ticks(3);
    rst_n = 1'b1;
    ticks(4);

    // Clean press on channel 0
    clear_obs(); c0 = cyc;
    btn_raw[0] = 1'b1;
    ticks(12);
    chk_int("clean_press_n", n_press[0], 1);
    chk_int("clean_press_t", t_press[0], c0 + 6);
    chk_int("clean_other_ch", n_press[1] + n_press[2], 0);
    btn_raw[0] = 1'b0;
    ticks(8);

    // Bounce 1,0,1,0 then held
    clear_obs(); c0 = cyc;
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1;
    ticks(10);
    chk_int("bounce_press_n", n_press[0], 1);
    chk_int("bounce_press_t", t_press[0], c0 + 10);
    chk_int("bounce_release_n", n_release[0], 0);
    btn_raw[0] = 1'b0;
    ticks(8);

    // Long press on channel 1
    clear_obs(); c0 = cyc;
    btn_raw[1] = 1'b1;
    ticks(20);
    btn_raw[1] = 1'b0;
    ticks(10);
    chk_int("long_press_t", t_press[1], c0 + 6);
    chk_int("long_n", n_long[1], 1);
    chk_int("long_t", t_long[1], c0 + 16);
    chk_int("long_release_t", t_release[1], c0 + 26);

    // Short press: no long pulse
    clear_obs(); c0 = cyc;
    btn_raw[0] = 1'b1;
    ticks(8);
    btn_raw[0] = 1'b0;
    ticks(10);
    chk_int("short_press_t", t_press[0], c0 + 6);
    chk_int("short_release_t", t_release[0], c0 + 14);
    chk_int("short_long_n", n_long[0], 0);

    // Active-low channel held through reset
    rst_n = 1'b0;
    btn_raw[2] = 1'b0;
    #1;
    check_zero("pol_rst_entry");
    ticks(4);
    clear_obs(); c0 = cyc;
    rst_n = 1'b1;
    ticks(10);
    chk_int("pol_press_n", n_press[2], 1);
    chk_int("pol_press_t", t_press[2], c0 + 6);
    btn_raw[2] = 1'b1;
    ticks(10);

    // Reset during hold
    clear_obs(); c0 = cyc;
    btn_raw[0] = 1'b1;
    ticks(9);
    chk_int("midhold_press_t", t_press[0], c0 + 6);
    rst_n = 1'b0;
    #1;
    check_zero("midhold_rst_entry");
    btn_raw[0] = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk_int("midhold_release_n", n_release[0], 0);
    chk_int("midhold_long_n", n_long[0], 0);

    // Random pin activity with occasional resets
    for (int ch = 0; ch < N; ch++) remain[ch] = 0;
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (remain[ch] == 0) begin
          btn_raw[ch] = 1'($urandom_range(0, 1));
          remain[ch]  = int'($urandom_range(1, 16));
        end
        remain[ch]--;
      end
      rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
